serial_listener: RTL and testbench
==================================

// Module: serial_listener
// PURPOSE
//   UART receiver, 8N1, LSB first, idle-high line; the receive counterpart of the Fomu serial transmitter.
//   Oversamples a pad input (e.g. user_4) on the 48 MHz global clock and recovers bytes by mid-bit sampling.
//   Delivers each byte on a valid/ready handshake, with sticky framing and overrun flags.
// PARAMETERS
//   CLKS_PER_BIT  5000  clk cycles per bit (48 MHz / 9600 baud); legal range >= 4
// PORTS
//   clk        in   1  48 MHz global clock (SB_GB output); all logic on posedge
//   rst_n      in   1  asynchronous, active-low reset
//   rx         in   1  serial line, asynchronous to clk; idle = 1
//   rx_data    out  8  received byte; stable while rx_valid = 1
//   rx_valid   out  1  byte available; held until accepted
//   rx_ready   in   1  consumer accepts the byte when rx_valid & rx_ready
//   busy       out  1  1 whenever the FSM is not IDLE
//   frame_err  out  1  sticky: stop bit sampled 0
//   overrun    out  1  sticky: new byte arrived while rx_valid was still unaccepted
//   err_clr    in   1  synchronous clear of frame_err and overrun
// BEHAVIOUR
//   Reset: 2-flop synchronizer = 1; FSM = IDLE; rx_data = 0x00; rx_valid, busy, frame_err, overrun = 0.
//   Reset has immediate effect mid-frame: a partial byte is discarded and no flag is set.
//   rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s only.
//   Bit counter width = $clog2(CLKS_PER_BIT). Bit index is 3 bits.
//   FSM:
//     IDLE  : rx_s == 0 -> START, counter = 0.
//     START : counts to CLKS_PER_BIT/2 - 1 (mid start bit).
//             If rx_s == 0 there -> DATA, counter = 0, bit index = 0.
//             If rx_s == 1 -> glitch; return to IDLE with no flags.
//     DATA  : at counter == CLKS_PER_BIT-1, sample rx_s into shift[bit index] (LSB first) and reset counter.
//             After bit 7 -> STOP.
//     STOP  : at counter == CLKS_PER_BIT-1, sample rx_s.
//             1 -> load rx_data, set rx_valid, go to IDLE.
//             0 -> set frame_err, drop the byte, go to BREAK.
//     BREAK : waits for rx_s == 1, then -> IDLE. A held-low line produces exactly one frame_err.
//   Handshake:
//     - rx_valid falls the cycle after rx_valid & rx_ready.
//     - rx_ready has no effect while rx_valid = 0.
//   New byte while rx_valid = 1 and not accepted in the same cycle: rx_data is overwritten, rx_valid
//   stays 1, and overrun is set.
//   New byte in the same cycle as an accept: new byte wins, rx_valid stays 1, and overrun is not set.
//   Error flags:
//     - err_clr clears both flags.
//     - If err_clr and a new error event fall in the same cycle, the set wins.
//   Latency: rx_valid rises 1 clk after the stop-bit sample. That is ~9.5 bit times + 3 clk after the
//   falling edge on rx.
//   Back-to-back frames: IDLE is re-entered at mid stop bit, so a start edge directly after the stop bit
//   is caught. A sender running ~4% fast is still received.
// TESTING (CLKS_PER_BIT=16 unless noted; the bench drives rx at 16 clk/bit)
//   1. Send 0x48 ('H') -> rx_valid rises ~155 clk after the start edge; rx_data = 0x48; frame_err = overrun = 0.
//   2. Send "Hello world!\n" back-to-back with rx_ready tied 1 -> 13 bytes in order, matching exactly, with no flags.
//   3. Send 0x55, then 0xAA with rx_ready = 0 -> rx_data = 0xAA and overrun = 1. A single err_clr pulse -> overrun = 0.
//   4. Send 0x00 with stop bit 0, then hold rx low for 40 bits -> one frame_err, no rx_valid, busy = 1 until rx
//      returns high.
//   5. Drive a 5-clk low glitch on idle rx -> FSM returns to IDLE, with no rx_valid and no flags.
//      Then assert rst_n = 0 at data bit 3 of a frame -> all outputs 0 within the same cycle; the next full
//      frame 0x3C is received correctly.
//   6. CLKS_PER_BIT=5000, send 0xA5 at 9600 baud -> rx_data = 0xA5; sender offsets of +/-3% are also received.

Source files
------------

// File: rtl/serial_listener.sv
// ============================================================================
// serial_listener: 8N1 UART receiver, mid-bit sampling, valid/ready output
// with sticky framing-error and overrun flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_listener #(
  parameter int CLKS_PER_BIT = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             fe_q, fe_d;
  logic             ov_q, ov_d;
  logic             w_rx_s;
  logic             w_new_byte;
  logic             w_frame_evt;

  assign w_rx_s = sync2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    fe_d        = fe_q;
    ov_d        = ov_q;
    w_new_byte  = 1'b0;
    w_frame_evt = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!w_rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == c_half_last) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == c_bit_last) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = w_rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == c_bit_last) begin
          cnt_d = '0;
          if (w_rx_s) begin
            w_new_byte = 1'b1;
            state_d    = S_IDLE;
          end else begin
            w_frame_evt = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (w_rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (valid_q && rx_ready) valid_d = 1'b0;
    if (w_new_byte) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end

    // Clear first so a coincident error event still sets its flag.
    if (err_clr) begin
      fe_d = 1'b0;
      ov_d = 1'b0;
    end
    if (w_frame_evt) fe_d = 1'b1;
    if (w_new_byte && valid_q && !rx_ready) ov_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = fe_q;
  assign overrun   = ov_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_listener.sv
// ============================================================================
// tb_serial_listener: directed bench for serial_listener (16 and 5000 clk/bit).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_listener;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       rx_ready2 = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data, rx_data2;
  logic       rx_valid, busy, frame_err, overrun;
  logic       rx_valid2, busy2, frame_err2, overrun2;

  int checks = 0;
  int failures = 0;
  int n;
  int base;
  byte unsigned rxq[$];
  byte unsigned msg[13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77,
                            8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};

  // One clock period is 100 time units, so 16 clk/bit is 1600 units.
  always #50 clk = ~clk;

  serial_listener #(.CLKS_PER_BIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .busy(busy), .frame_err(frame_err), .overrun(overrun),
    .err_clr(err_clr)
  );

  serial_listener #(.CLKS_PER_BIT(5000)) dut2 (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .rx_ready(rx_ready2), .busy(busy2), .frame_err(frame_err2), .overrun(overrun2),
    .err_clr(err_clr)
  );

  always @(negedge clk) begin
    if (rx_valid && rx_ready) rxq.push_back(rx_data);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int bt);
    rx = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bt);
    end
    rx = stop_bit;
    #(bt);
  endtask

  task automatic wait_valid(input int bound, output int cnt);
    cnt = 0;
    while (cnt < bound) begin
      @(negedge clk);
      cnt++;
      if (rx_valid) break;
    end
  endtask

  task automatic accept;
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clr;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_valid", rx_valid, 0);
    check_val("rst_data", rx_data, 8'h00);
    check_val("rst_busy", busy, 0);
    check_val("rst_flags", {frame_err, overrun}, 2'b00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte, latency from the start edge
    @(posedge clk);
    fork
      begin #10; send_byte(8'h48, 1'b1, 1600); end
      wait_valid(400, n);
    join
    check_val("t1_latency", n - 1, 155);
    check_val("t1_valid", rx_valid, 1);
    check_val("t1_data", rx_data, 8'h48);
    check_val("t1_flags", {frame_err, overrun}, 2'b00);
    check_val("t1_busy", busy, 0);
    accept();
    check_val("t1_accept", rx_valid, 0);

    // Back-to-back string with ready tied high
    base = rxq.size();
    rx_ready = 1'b1;
    for (int i = 0; i < 13; i++) send_byte(msg[i], 1'b1, 1600);
    repeat (20) @(negedge clk);
    rx_ready = 1'b0;
    check_val("t2_count", rxq.size() - base, 13);
    for (int i = 0; i < 13; i++)
      check_val($sformatf("t2_byte%0d", i),
                (base + i < rxq.size()) ? 32'(rxq[base + i]) : 32'h100, 32'(msg[i]));
    check_val("t2_flags", {frame_err, overrun}, 2'b00);

    // Overrun and its clear
    send_byte(8'h55, 1'b1, 1600);
    send_byte(8'hAA, 1'b1, 1600);
    repeat (5) @(negedge clk);
    check_val("t3_valid", rx_valid, 1);
    check_val("t3_data", rx_data, 8'hAA);
    check_val("t3_overrun", overrun, 1);
    check_val("t3_fe", frame_err, 0);
    pulse_clr();
    check_val("t3_clr", overrun, 0);
    accept();
    check_val("t3_accept", rx_valid, 0);

    // Framing error followed by a long break
    send_byte(8'h00, 1'b0, 1600);
    check_val("t4_fe", frame_err, 1);
    check_val("t4_novalid", rx_valid, 0);
    pulse_clr();
    #(40 * 1600);
    check_val("t4_one_fe", frame_err, 0);
    check_val("t4_busy_hold", busy, 1);
    check_val("t4_novalid2", rx_valid, 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check_val("t4_busy_release", busy, 0);

    // Glitch on idle line, with a byte parked in rx_data
    send_byte(8'h81, 1'b1, 1600);
    repeat (3) @(negedge clk);
    check_val("t5_pre_data", rx_data, 8'h81);
    @(posedge clk);
    #10 rx = 1'b0;
    repeat (4) @(negedge clk);
    check_val("t5_glitch_busy", busy, 1);
    #160 rx = 1'b1;
    repeat (30) @(negedge clk);
    check_val("t5_glitch_idle", busy, 0);
    check_val("t5_glitch_data", rx_data, 8'h81);
    check_val("t5_glitch_flags", {frame_err, overrun}, 2'b00);

    // Reset asserted in data bit 3 of a frame
    @(posedge clk);
    #10 rx = 1'b0;
    #(1600 * 4 + 800);
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_busy", busy, 0);
    check_val("t5_rst_valid", rx_valid, 0);
    check_val("t5_rst_data", rx_data, 8'h00);
    check_val("t5_rst_flags", {frame_err, overrun}, 2'b00);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_val("t5_post_idle", {busy, rx_valid}, 2'b00);
    send_byte(8'h3C, 1'b1, 1600);
    repeat (3) @(negedge clk);
    check_val("t5_3c_valid", rx_valid, 1);
    check_val("t5_3c_data", rx_data, 8'h3C);
    check_val("t5_3c_flags", {frame_err, overrun}, 2'b00);
    accept();

    // Sender clock offsets of +3% and -3%
    send_byte(8'hA5, 1'b1, 1648);
    repeat (3) @(negedge clk);
    check_val("t6_slow_data", {rx_valid, rx_data}, 9'h1A5);
    accept();
    send_byte(8'h5A, 1'b1, 1552);
    repeat (3) @(negedge clk);
    check_val("t6_fast_data", {rx_valid, rx_data}, 9'h15A);
    check_val("t6_flags", {frame_err, overrun}, 2'b00);
    accept();

    // Full-rate divider: 5000 clk per bit
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'hA5, 1'b1, 500000);
    n = 0;
    while (!rx_valid2 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_val("t6_5000_valid", rx_valid2, 1);
    check_val("t6_5000_data", rx_data2, 8'hA5);
    check_val("t6_5000_flags", {frame_err2, overrun2}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
